// File: rtl/sata_dma_pkg.sv
// rtl/sata_dma_pkg.sv - shared types and helpers for the SATA DMA receive path
package sata_dma_pkg;

  typedef enum logic {HEAD, BODY} hstrip_state_t;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sata_stream_skid.sv
// rtl/sata_stream_skid.sv - 2-entry registered skid buffer with val/rdy on both sides
module sata_stream_skid #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_wr_val,
  output logic             o_wr_rdy,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_rd_val,
  input  logic             i_rd_rdy
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  // Ready comes from the occupancy register only, so it never sees i_rd_rdy.
  assign o_wr_rdy = (r_cnt != 2'd2);
  assign o_rd_val = (r_cnt != 2'd0);
  assign o_rd_dat = r_mem[r_rp];
  assign w_push   = i_wr_val & o_wr_rdy;
  assign w_pop    = o_rd_val & i_rd_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wr_dat;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sata_dma_rx_head_stripper.sv
// rtl/sata_dma_rx_head_stripper.sv - strips 0..HWORDS_MAX leading header words per RX frame
module sata_dma_rx_head_stripper
  import sata_dma_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int HWORDS_MAX = 8,
  parameter int LWIDTH     = $clog2(HWORDS_MAX+1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [LWIDTH-1:0]            hdr_len,
  input  logic [DWIDTH-1:0]            i_dat,
  input  logic                         i_val,
  input  logic                         i_eop,
  input  logic                         i_err,
  output logic                         i_rdy,
  output logic [DWIDTH-1:0]            o_dat,
  output logic                         o_val,
  output logic                         o_eop,
  output logic                         o_err,
  input  logic                         o_rdy,
  output logic [HWORDS_MAX*DWIDTH-1:0] hdr_dat,
  output logic                         hdr_vld,
  output logic                         short_err
);

  hstrip_state_t               r_state;
  logic [LWIDTH-1:0]           r_cnt;
  logic [LWIDTH-1:0]           r_len_q;
  logic                        r_err_acc;
  logic                        r_hdr_vld;
  logic                        r_short_err;
  logic [HWORDS_MAX*DWIDTH-1:0] r_hdr_dat;

  logic                        w_first;
  logic [LWIDTH-1:0]           w_len_now;
  logic [LWIDTH-1:0]           w_len_eff;
  logic [LWIDTH-1:0]           w_cnt_inc;
  logic                        w_last_hdr;
  logic                        w_pay;
  logic                        w_acc;
  logic                        w_push;
  logic                        w_skid_rdy;
  logic [DWIDTH+1:0]           w_skid_in;
  logic [DWIDTH+1:0]           w_skid_out;

  assign w_first    = (r_state == HEAD) && (r_cnt == '0);
  assign w_len_now  = LWIDTH'(clamp_len(32'(hdr_len), HWORDS_MAX));
  assign w_len_eff  = w_first ? w_len_now : r_len_q;
  assign w_cnt_inc  = r_cnt + LWIDTH'(1);
  assign w_last_hdr = (w_cnt_inc == w_len_eff);
  // A zero-length header makes the first word a payload word, so it must obey skid ready.
  assign w_pay      = (r_state == BODY) || (w_first && (w_len_now == '0));
  assign i_rdy      = w_pay ? w_skid_rdy : 1'b1;
  assign w_acc      = i_val & i_rdy;
  assign w_push     = w_acc & w_pay;
  assign w_skid_in  = {i_eop, i_err | (i_eop & r_err_acc), i_dat};

  assign hdr_vld    = r_hdr_vld | (reset_n & w_push & w_first);
  assign short_err  = r_short_err;
  assign hdr_dat    = r_hdr_dat;
  assign o_dat      = w_skid_out[DWIDTH-1:0];
  assign o_err      = w_skid_out[DWIDTH];
  assign o_eop      = w_skid_out[DWIDTH+1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= HEAD;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_err_acc   <= 1'b0;
      r_hdr_vld   <= 1'b0;
      r_short_err <= 1'b0;
      r_hdr_dat   <= '0;
    end else begin
      r_hdr_vld   <= 1'b0;
      r_short_err <= 1'b0;
      if (w_acc) begin
        if (w_first) begin
          r_len_q <= w_len_now;
        end
        if (w_pay) begin
          if (i_eop) begin
            r_state   <= HEAD;
            r_err_acc <= 1'b0;
          end else begin
            r_state <= BODY;
          end
        end else begin
          for (int k = 0; k < HWORDS_MAX; k++) begin
            if (r_cnt == LWIDTH'(k)) begin
              r_hdr_dat[k*DWIDTH +: DWIDTH] <= i_dat;
            end
          end
          if (i_eop) begin
            r_cnt       <= '0;
            r_err_acc   <= 1'b0;
            r_hdr_vld   <= w_last_hdr;
            r_short_err <= ~w_last_hdr;
          end else if (w_last_hdr) begin
            r_state   <= BODY;
            r_cnt     <= '0;
            r_hdr_vld <= 1'b1;
            r_err_acc <= r_err_acc | i_err;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_err_acc <= r_err_acc | i_err;
          end
        end
      end
    end
  end

  sata_stream_skid #(
    .WIDTH(DWIDTH+2)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr_dat(w_skid_in),
    .i_wr_val(w_push),
    .o_wr_rdy(w_skid_rdy),
    .o_rd_dat(w_skid_out),
    .o_rd_val(o_val),
    .i_rd_rdy(o_rdy)
  );

endmodule

// File: tb/tb_sata_dma_rx_head_stripper.sv
// tb/tb_sata_dma_rx_head_stripper.sv - directed and random checks of the RX header stripper
module tb_sata_dma_rx_head_stripper;

  logic         clk;
  logic         reset_n;
  logic [3:0]   hdr_len;
  logic [31:0]  i_dat;
  logic         i_val;
  logic         i_eop;
  logic         i_err;
  logic         i_rdy;
  logic [31:0]  o_dat;
  logic         o_val;
  logic         o_eop;
  logic         o_err;
  logic         o_rdy;
  logic [255:0] hdr_dat;
  logic         hdr_vld;
  logic         short_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          got_cyc[$];
  int          lat_q[$];
  logic [31:0] exp_hdr[8];
  int          exp_hv = 0;
  int          exp_se = 0;
  int          hv_cnt = 0;
  int          se_cnt = 0;

  logic [31:0] fw[$];
  bit          fe[$];

  bit          rdy_rand  = 0;
  logic        rdy_fixed = 1;
  bit          prev_stall = 0;
  logic [33:0] prev_out;

  sata_dma_rx_head_stripper #(
    .DWIDTH(32),
    .HWORDS_MAX(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hdr_len  (hdr_len),
    .i_dat    (i_dat),
    .i_val    (i_val),
    .i_eop    (i_eop),
    .i_err    (i_err),
    .i_rdy    (i_rdy),
    .o_dat    (o_dat),
    .o_val    (o_val),
    .o_eop    (o_eop),
    .o_err    (o_err),
    .o_rdy    (o_rdy),
    .hdr_dat  (hdr_dat),
    .hdr_vld  (hdr_vld),
    .short_err(short_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    o_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_rdy = rdy_rand ? 1'($urandom_range(1)) : rdy_fixed;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall) chk("hold_while_stalled", {o_val, o_eop, o_err, o_dat}, {1'b1, prev_out});
    prev_stall = (reset_n === 1'b1) && (o_val === 1'b1) && (o_rdy === 1'b0);
    prev_out   = {o_eop, o_err, o_dat};
    if (reset_n === 1'b1 && o_val === 1'b1 && o_rdy === 1'b1) begin
      got_q.push_back({o_eop, o_err, o_dat});
      got_cyc.push_back(cyc);
    end
    if (hdr_vld === 1'b1) hv_cnt++;
    if (short_err === 1'b1) se_cnt++;
  end

  // Expected results for one frame held in fw/fe, straight from the stripping rules.
  task automatic model_frame(input int hl);
    int L = (hl > 8) ? 8 : hl;
    int n = fw.size();
    bit any_hdr_err = 0;
    if (n < L) begin
      exp_se++;
      for (int i = 0; i < n; i++) exp_hdr[i] = fw[i];
    end else begin
      exp_hv++;
      for (int i = 0; i < L; i++) begin
        exp_hdr[i] = fw[i];
        any_hdr_err |= fe[i];
      end
      for (int i = L; i < n; i++)
        exp_q.push_back({(i == n-1), fe[i] | ((i == n-1) & any_hdr_err), fw[i]});
    end
  endtask

  task automatic put_word(input logic [31:0] d, input bit eop, input bit err,
                          input bit is_hdr, input bit first_len0, input bit track_lat);
    bit acc = 0;
    i_dat = d;
    i_val = 1'b1;
    i_eop = eop;
    i_err = err;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (is_hdr) chk("i_rdy_on_header", i_rdy, 1'b1);
      if (i_rdy === 1'b1) begin
        if (first_len0) chk("hdr_vld_same_cycle", hdr_vld, 1'b1);
        if (track_lat) lat_q.push_back(cyc);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    i_val = 1'b0;
    i_eop = 1'b0;
    i_err = 1'b0;
  endtask

  task automatic send_frame(input int hl, input bit track_lat, input bit gap);
    int L = (hl > 8) ? 8 : hl;
    int n = fw.size();
    model_frame(hl);
    hdr_len = 4'(hl);
    for (int i = 0; i < n; i++) begin
      put_word(fw[i], (i == n-1), fe[i], (i < L), (i == 0 && L == 0), track_lat && (i >= L));
      if (i == 0) hdr_len = 4'($urandom_range(15));
    end
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic make_frame(input int n, input int err_pct);
    fw.delete();
    fe.delete();
    for (int i = 0; i < n; i++) begin
      fw.push_back($urandom);
      fe.push_back($urandom_range(99) < err_pct);
    end
  endtask

  task automatic check_all(input string tag);
    for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    for (int i = 0; i < lat_q.size() && i < got_cyc.size(); i++)
      chk({tag, "_latency"}, got_cyc[i] - lat_q[i], 1);
    chk({tag, "_hdr_vld_pulses"}, hv_cnt, exp_hv);
    chk({tag, "_short_err_pulses"}, se_cnt, exp_se);
    for (int k = 0; k < 8; k++) chk({tag, "_hdr_slot"}, hdr_dat[k*32 +: 32], exp_hdr[k]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    lat_q.delete();
    hv_cnt = 0;
    se_cnt = 0;
    exp_hv = 0;
    exp_se = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    hdr_len = 4'd0;
    i_dat   = 32'd0;
    i_val   = 1'b0;
    i_eop   = 1'b0;
    i_err   = 1'b0;
    for (int k = 0; k < 8; k++) exp_hdr[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_o_val", o_val, 1'b0);
    chk("rst_o_dat", {o_eop, o_err, o_dat}, 34'd0);
    chk("rst_hdr_dat", hdr_dat, 256'd0);
    chk("rst_hdr_vld", hdr_vld, 1'b0);
    chk("rst_short_err", short_err, 1'b0);
    chk("rst_i_rdy", i_rdy, 1'b1);
    hv_cnt = 0;
    se_cnt = 0;
    @(posedge clk);
    #1;

    make_frame(5, 0);
    send_frame(1, 1, 1);
    check_all("t1_len1");

    make_frame(3, 0);
    send_frame(5, 0, 1);
    make_frame(4, 0);
    send_frame(2, 0, 1);
    check_all("t2_short");

    make_frame(4, 0);
    send_frame(0, 1, 1);
    make_frame(11, 0);
    send_frame(12, 1, 1);
    check_all("t3_len0_clamp");

    make_frame(6, 0);
    fe[1] = 1'b1;
    send_frame(2, 0, 1);
    make_frame(6, 0);
    send_frame(2, 0, 1);
    check_all("t4_err");

    rdy_rand = 1;
    for (int f = 0; f < 30; f++) begin
      make_frame($urandom_range(1, 10), (f < 10) ? 0 : 12);
      send_frame((f < 10) ? 1 : $urandom_range(15), 0, (f >= 10));
    end
    check_all("t5_random");
    rdy_rand = 0;

    rdy_fixed = 1'b0;
    hdr_len = 4'd1;
    put_word(32'hB000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put_word(32'hB000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put_word(32'hB000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_hv++;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_hdr[k] = 32'd0;
    @(negedge clk);
    chk("t6_o_val_after_rst", o_val, 1'b0);
    chk("t6_i_rdy_after_rst", i_rdy, 1'b1);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    make_frame(4, 0);
    send_frame(2, 0, 1);
    check_all("t6_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
